m_cp0_gen: RTL and testbench

//  Parametrised coprocessor-0 for the 5-stage MIPS core, placed in stage M. Holds SR, Cause, EPC
//  and PRId, plus a new Count/Compare timer. Arbitrates interrupts against precise exceptions and

---
 rtl/m_cp0_gen_pkg.sv | 65 ++++++
 rtl/m_cp0_gen_if.sv | 34 +++
 rtl/m_cp0_gen_timer.sv | 37 +++
 rtl/m_cp0_gen.sv | 120 ++++++++++++
 tb/tb_m_cp0_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_cp0_gen_pkg.sv
// Shared definitions for the M-stage coprocessor 0: register addresses, field
// positions and packing helpers for the SR and Cause views.
package m_cp0_gen_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam logic [4:0] EX_INT = 5'd0;

    localparam int IM_LO   = 10;
    localparam int IP_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_LO  = 2;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_INT  = 2'd1,
        REQ_EXC  = 2'd2
    } req_kind_e;

    function automatic logic [31:0] sr_word(sr_t s);
        logic [31:0] w;
        w = '0;
        w[IM_LO +: 6] = s.im;
        w[EXL_BIT]    = s.exl;
        w[IE_BIT]     = s.ie;
        return w;
    endfunction

    function automatic sr_t sr_from_word(logic [31:0] w);
        sr_t s;
        s.im  = w[IM_LO +: 6];
        s.exl = w[EXL_BIT];
        s.ie  = w[IE_BIT];
        return s;
    endfunction

    function automatic logic [31:0] cause_word(cause_t c);
        logic [31:0] w;
        w = '0;
        w[BD_BIT]      = c.bd;
        w[IP_LO +: 6]  = c.ip;
        w[EXC_LO +: 5] = c.exc_code;
        return w;
    endfunction

endpackage

// File: rtl/m_cp0_gen_if.sv
// Pipeline-side port bundle of coprocessor 0: mfc0/mtc0 access, M-stage
// exception context and the flush request back to the core.
interface m_cp0_gen_if #(
    parameter int NUM_HWINT = 6
);
    // req is a combinational take-it-now strobe with no ready path: the core
    // must flush and redirect on every cycle req is high, and cp0 commits its
    // exception state on that same rising edge.
    logic [4:0]           a1;
    logic [4:0]           a2;
    logic [31:0]          cwd;
    logic                 cwe;
    logic [29:0]          pc;
    logic                 bd_in;
    logic [4:0]           ex_code_in;
    logic [NUM_HWINT-1:0] hwint;
    logic                 exl_clr;
    logic                 req;
    logic [31:0]          epc_out;
    logic [31:0]          cp0_out;
    logic                 int_en;
    logic                 timer_irq;

    modport master (
        output a1, a2, cwd, cwe, pc, bd_in, ex_code_in, hwint, exl_clr,
        input  req, epc_out, cp0_out, int_en, timer_irq
    );

    modport slave (
        input  a1, a2, cwd, cwe, pc, bd_in, ex_code_in, hwint, exl_clr,
        output req, epc_out, cp0_out, int_en, timer_irq
    );

endinterface

// File: rtl/m_cp0_gen_timer.sv
// Count/Compare timer: Count free-runs every cycle, timer_irq latches when the
// next Count reaches Compare and is cleared by any Compare write.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wd,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_irq
);

    logic [31:0] next_count;

    always_comb begin
        next_count = we_count ? wd : count + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            compare   <= '0;
            timer_irq <= 1'b0;
        end else begin
            count <= next_count;
            if (we_compare) begin
                compare   <= wd;
                timer_irq <= 1'b0;
            end else if (next_count == compare) begin
                // Matching on next_count keeps the reset state (0/0) quiet.
                timer_irq <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_cp0_gen.sv
// Coprocessor 0 in stage M: SR/Cause/EPC/PRId plus optional Count/Compare,
// arbitrating interrupts over precise exceptions and raising req to flush.
module m_cp0_gen
    import m_cp0_gen_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter bit          HAS_TIMER = 1'b1,
    parameter logic [31:0] PRID      = 32'h2021_0707
) (
    input logic       clk,
    input logic       reset,
    m_cp0_gen_if.slave bus
);

    sr_t         sr;
    cause_t      cause;
    logic [29:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tirq;

    logic [5:0]  hw_ext;
    logic [5:0]  irq_vec;
    logic        int_pend;
    logic        exc_pend;
    logic        req;
    logic        wr_en;
    req_kind_e   req_kind;
    logic [31:0] rdata;

    always_comb begin
        hw_ext                  = '0;
        hw_ext[NUM_HWINT-1:0]   = bus.hwint;
        irq_vec                 = hw_ext;
        irq_vec[5]              = hw_ext[5] | tirq;
    end

    // Pending checks use the live irq_vec so a line is seen the cycle it rises.
    always_comb begin
        int_pend = reset & (|(irq_vec & sr.im)) & sr.ie & ~sr.exl;
        exc_pend = reset & (bus.ex_code_in != 5'd0) & ~sr.exl;
        req      = int_pend | exc_pend;
        wr_en    = bus.cwe & ~req;
    end

    always_comb begin
        if (int_pend) begin
            req_kind = REQ_INT;
        end else if (exc_pend) begin
            req_kind = REQ_EXC;
        end else begin
            req_kind = REQ_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr    <= '0;
            cause <= '0;
            epc   <= '0;
        end else begin
            cause.ip <= irq_vec;
            if (req_kind != REQ_NONE) begin
                sr.exl         <= 1'b1;
                cause.bd       <= bus.bd_in;
                cause.exc_code <= (req_kind == REQ_INT) ? EX_INT : bus.ex_code_in;
                epc            <= bus.pc - {29'd0, bus.bd_in};
            end else begin
                if (wr_en && bus.a2 == CP0_SR) begin
                    sr <= sr_from_word(bus.cwd);
                end
                if (wr_en && bus.a2 == CP0_EPC) begin
                    epc <= bus.cwd[31:2];
                end
                // Placed after the SR write so eret wins on the EXL bit.
                if (bus.exl_clr) begin
                    sr.exl <= 1'b0;
                end
            end
        end
    end

    generate
        if (HAS_TIMER) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .we_count   (wr_en && bus.a2 == CP0_COUNT),
                .we_compare (wr_en && bus.a2 == CP0_COMPARE),
                .wd         (bus.cwd),
                .count      (count),
                .compare    (compare),
                .timer_irq  (tirq)
            );
        end else begin : g_no_timer
            assign count   = '0;
            assign compare = '0;
            assign tirq    = 1'b0;
        end
    endgenerate

    always_comb begin
        case (bus.a1)
            CP0_SR:      rdata = sr_word(sr);
            CP0_CAUSE:   rdata = cause_word(cause);
            CP0_EPC:     rdata = {epc, 2'b00};
            CP0_PRID:    rdata = PRID;
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
            default:     rdata = 32'h0;
        endcase
    end

    assign bus.req       = req;
    assign bus.int_en    = int_pend;
    assign bus.epc_out   = {epc, 2'b00};
    assign bus.cp0_out   = rdata;
    assign bus.timer_irq = tirq;

endmodule

// File: tb/tb_m_cp0_gen.sv
// Bench for m_cp0_gen: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a register-level model.
module tb_m_cp0_gen;

    localparam logic [31:0] PRID_V = 32'h2021_0707;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    m_cp0_gen_if #(.NUM_HWINT(6)) bus ();

    m_cp0_gen #(
        .NUM_HWINT (6),
        .HAS_TIMER (1'b1),
        .PRID      (PRID_V)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: architectural register words ----------------
    logic [31:0] m_sr, m_cause, m_epcw, m_count, m_compare;
    logic        m_tirq;
    logic        u_int, u_exc, u_wr;
    logic [5:0]  u_iv;
    logic [31:0] u_nc;

    function automatic logic [5:0] m_irq();
        return bus.hwint | {m_tirq, 5'b0};
    endfunction

    function automatic logic m_int();
        return reset && ((m_irq() & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_exc();
        return reset && (bus.ex_code_in != 5'd0) && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epcw;
            5'd15:   return PRID_V;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sr = 0; m_cause = 0; m_epcw = 0; m_count = 0; m_compare = 0; m_tirq = 0;
        end else begin
            u_int = m_int();
            u_exc = m_exc();
            u_iv  = m_irq();
            u_wr  = bus.cwe && !(u_int || u_exc);
            u_nc  = (u_wr && bus.a2 == 5'd9) ? bus.cwd : m_count + 32'd1;
            if (u_wr && bus.a2 == 5'd11) begin
                m_compare = bus.cwd;
                m_tirq    = 1'b0;
            end else if (u_nc == m_compare) begin
                m_tirq = 1'b1;
            end
            m_count         = u_nc;
            m_cause[15:10]  = u_iv;
            if (u_int || u_exc) begin
                m_sr[1]       = 1'b1;
                m_cause[31]   = bus.bd_in;
                m_cause[6:2]  = u_int ? 5'd0 : bus.ex_code_in;
                m_epcw        = {bus.pc - {29'd0, bus.bd_in}, 2'b00};
            end else begin
                if (u_wr && bus.a2 == 5'd12) m_sr = bus.cwd & 32'h0000_FC03;
                if (u_wr && bus.a2 == 5'd14) m_epcw = {bus.cwd[31:2], 2'b00};
                if (bus.exl_clr) m_sr[1] = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_req",    {31'd0, bus.req},       {31'd0, m_int() | m_exc()});
            chk("mon_int_en", {31'd0, bus.int_en},    {31'd0, m_int()});
            chk("mon_cp0_out", bus.cp0_out,           m_read(bus.a1));
            chk("mon_epc_out", bus.epc_out,           m_epcw);
            chk("mon_timer",  {31'd0, bus.timer_irq}, {31'd0, m_tirq});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.a1 = 5'd0; bus.a2 = 5'd0; bus.cwd = 32'h0; bus.cwe = 1'b0;
        bus.pc = 30'h0; bus.bd_in = 1'b0; bus.ex_code_in = 5'd0;
        bus.hwint = 6'h0; bus.exl_clr = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cwe = 1'b1; bus.a2 = a; bus.cwd = d;
    endtask

    int addrs[8] = '{9, 11, 12, 13, 14, 15, 0, 7};

    initial begin
        idle();
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        bus.a1 = 5'd12;
        @(negedge clk);
        chk("rst_req", {31'd0, bus.req}, 32'd0);
        chk("rst_sr", bus.cp0_out, 32'h0);
        chk("rst_epc", bus.epc_out, 32'h0);
        @(posedge clk); #1 reset = 1'b1;

        // Interrupt on hwint[0] with IE and IM[0]
        next_cycle(); mtc0(5'd12, 32'h0000_0401);
        next_cycle(); bus.hwint = 6'h01; bus.pc = 30'h0000_0C05;
        @(negedge clk);
        chk("t2_req", {31'd0, bus.req}, 32'd1);
        chk("t2_int_en", {31'd0, bus.int_en}, 32'd1);
        next_cycle(); bus.a1 = 5'd13;
        @(negedge clk);
        chk("t2_cause", bus.cp0_out, 32'h0000_0400);
        chk("t2_epc", bus.epc_out, 32'h0000_3014);
        next_cycle(); bus.a1 = 5'd12;
        @(negedge clk);
        chk("t2_sr_exl", bus.cp0_out, 32'h0000_0403);

        // Reserved-instruction exception from a delay slot
        next_cycle(); bus.exl_clr = 1'b1; mtc0(5'd12, 32'h0000_0400);
        next_cycle(); bus.ex_code_in = 5'd10; bus.bd_in = 1'b1; bus.pc = 30'h0000_0C06; bus.a1 = 5'd12;
        @(negedge clk);
        chk("t3_req", {31'd0, bus.req}, 32'd1);
        chk("t3_int_en", {31'd0, bus.int_en}, 32'd0);
        chk("t3_sr", bus.cp0_out, 32'h0000_0400);
        next_cycle(); bus.a1 = 5'd13;
        @(negedge clk);
        chk("t3_cause", bus.cp0_out, 32'h8000_0028);
        chk("t3_epc", bus.epc_out, 32'h0000_3014);
        next_cycle(); bus.exl_clr = 1'b1; bus.a1 = 5'd12;
        @(negedge clk);
        chk("t3_sr_before_eret", bus.cp0_out, 32'h0000_0402);
        next_cycle(); bus.a1 = 5'd12;
        @(negedge clk);
        chk("t3_sr_after_eret", bus.cp0_out, 32'h0000_0400);

        // EXL masks everything while Cause.IP keeps tracking the lines
        next_cycle(); mtc0(5'd12, 32'h0000_FC03);
        next_cycle(); bus.hwint = 6'h3F; bus.ex_code_in = 5'd4; bus.a1 = 5'd12;
        @(negedge clk);
        chk("t4_sr", bus.cp0_out, 32'h0000_FC03);
        chk("t4_req", {31'd0, bus.req}, 32'd0);
        next_cycle(); bus.hwint = 6'h3F; bus.ex_code_in = 5'd4; bus.a1 = 5'd13;
        @(negedge clk);
        chk("t4_cause_ip", bus.cp0_out, 32'h8000_FC28);
        chk("t4_req2", {31'd0, bus.req}, 32'd0);
        next_cycle(); bus.exl_clr = 1'b1; mtc0(5'd12, 32'h0);

        // Timer match, interrupt through line 5, clear by Compare write
        next_cycle(); mtc0(5'd11, 32'h0000_0014);
        next_cycle(); mtc0(5'd9, 32'h0000_0010);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); bus.a1 = 5'd9;
            @(negedge clk);
            chk("t5_count", bus.cp0_out, 32'h0000_0010 + 32'(i));
            chk("t5_timer", {31'd0, bus.timer_irq}, (i == 4) ? 32'd1 : 32'd0);
        end
        next_cycle(); mtc0(5'd12, 32'h0000_8001);
        next_cycle();
        @(negedge clk);
        chk("t5_req", {31'd0, bus.req}, 32'd1);
        chk("t5_int_en", {31'd0, bus.int_en}, 32'd1);
        next_cycle(); mtc0(5'd11, 32'h0000_0020);
        next_cycle(); bus.a1 = 5'd13;
        @(negedge clk);
        chk("t5_timer_clr", {31'd0, bus.timer_irq}, 32'd0);
        chk("t5_cause", bus.cp0_out, 32'h0000_8000);

        // Count wrap match; mtc0 SR dropped under req
        next_cycle(); bus.exl_clr = 1'b1;
        next_cycle(); mtc0(5'd11, 32'h0);
        next_cycle(); mtc0(5'd9, 32'hFFFF_FFFE);
        next_cycle(); bus.a1 = 5'd9;
        @(negedge clk);
        chk("t6_count_fe", bus.cp0_out, 32'hFFFF_FFFE);
        next_cycle(); bus.a1 = 5'd9;
        @(negedge clk);
        chk("t6_count_ff", bus.cp0_out, 32'hFFFF_FFFF);
        chk("t6_timer0", {31'd0, bus.timer_irq}, 32'd0);
        next_cycle(); bus.a1 = 5'd9; mtc0(5'd12, 32'h0);
        @(negedge clk);
        chk("t6_count_wrap", bus.cp0_out, 32'h0);
        chk("t6_timer1", {31'd0, bus.timer_irq}, 32'd1);
        chk("t6_req", {31'd0, bus.req}, 32'd1);
        next_cycle(); bus.a1 = 5'd12;
        @(negedge clk);
        chk("t6_sr_kept", bus.cp0_out, 32'h0000_8003);
        next_cycle(); bus.exl_clr = 1'b1; mtc0(5'd11, 32'h0000_1000);

        // Asynchronous reset in the middle of operation
        next_cycle(); mtc0(5'd12, 32'h0000_FC01);
        next_cycle(); bus.a1 = 5'd12;
        @(negedge clk);
        chk("t1_sr_set", bus.cp0_out, 32'h0000_FC01);
        next_cycle(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.a1 = 5'(addrs[i]);
            @(negedge clk);
            chk("t1_rst_read", bus.cp0_out, 32'h0);
            chk("t1_rst_req", {31'd0, bus.req}, 32'd0);
            chk("t1_rst_timer", {31'd0, bus.timer_irq}, 32'd0);
            next_cycle();
        end
        reset = 1'b1;

        // Randomized traffic checked by the compare process
        for (int n = 0; n < 2000; n++) begin
            next_cycle();
            if (n == 900) reset = 1'b0;
            if (n == 903) reset = 1'b1;
            bus.a1 = 5'(addrs[$urandom_range(0, 7)]);
            if ($urandom_range(0, 3) == 0) begin
                bus.cwe = 1'b1;
                bus.a2  = 5'(addrs[$urandom_range(0, 7)]);
                bus.cwd = $urandom;
                if (bus.a2 == 5'd11 && $urandom_range(0, 1) == 1)
                    bus.cwd = m_count + 32'($urandom_range(1, 12));
            end
            bus.hwint      = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'h0;
            bus.ex_code_in = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.bd_in      = 1'($urandom_range(0, 1));
            bus.pc         = 30'($urandom);
            bus.exl_clr    = ($urandom_range(0, 4) == 0);
        end

        next_cycle();
        @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
